uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Serial UART transmitter that drives the pin side of the memory-mapped TX path.
//  Inputs come from the TX flag register (bit 0 = start) and the TX data register (bits [7:0]).
//  Sends one 8-bit frame, LSB first: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
//  Pulses tx_done when the frame ends, so the control logic can clear the TX flag.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200     line rate, bit/s; BIT_TICKS = CLK_FREQ/BAUD_RATE (integer, >=2)
//  PARITY_EN   0           1 = insert parity bit after data bits
//  PARITY_ODD  0           1 = odd parity, 0 = even parity (ignored if PARITY_EN=0)
//  STOP_BITS   1           number of stop bits, 1 or 2
// PORTS
//  clk       in   1  system clock; all state changes on the rising edge
//  rst       in   1  asynchronous reset, active-low
//  tx_start  in   1  level request; driven by TX flag register bit 0
//  tx_data   in   8  byte to send; driven by TX data register bits [7:0]
//  tx        out  1  serial line, idle high, registered
//  tx_busy   out  1  high from the accept cycle until the last stop bit completes
//  tx_done   out  1  one-cycle pulse at frame end
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, tx=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0, armed=0.
//   - Reset mid-frame aborts the frame immediately. tx returns high with no glitch low.
//  Arming (level-flag protection):
//   - armed is set on any cycle in IDLE where tx_start=0.
//   - armed is cleared when a frame is accepted.
//   - A flag held high after tx_done therefore never causes a second frame.
//  Accept: edge where state=IDLE and tx_start=1 and armed=1. On that edge:
//   - latch tx_data into shift register; compute parity bit (XOR of bits, inverted if PARITY_ODD)
//   - tx_busy<=1, state<=START, tx<=0
//   - Later changes on tx_data or tx_start do not affect the frame in flight.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - Each non-IDLE state holds tx for exactly BIT_TICKS cycles.
//   - Baud counter runs 0..BIT_TICKS-1 and wraps to 0 on the bit boundary.
//   - Bit boundary advances the state or the bit index.
//   - DATA: tx=shift[0], shift right each boundary; leaves after bit index 7 (3-bit index wraps 7->0).
//   - PARITY: entered only if PARITY_EN=1; tx=parity bit.
//   - STOP: tx=1 for STOP_BITS*BIT_TICKS cycles.
//  Frame end: on the final STOP boundary edge:
//   - state<=IDLE, tx_busy<=0, tx_done<=1 for that one cycle; tx stays 1.
//   - Next accept is possible no earlier than the following edge, and only if armed.
//  Latency: tx falls on the accept edge.
//   - Frame length = BIT_TICKS*(1+8+PARITY_EN+STOP_BITS) cycles.
//   - tx_done is asserted in the cycle after the last frame cycle.
//  Simultaneous events:
//   - tx_start asserted while busy is ignored. It does not arm, because arming happens only in IDLE.
//   - tx_start=0 at the frame-end edge arms on the next IDLE cycle.
// TESTING (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_TICKS=10)
//  1. Reset values: hold rst=0 -> tx=1, tx_busy=0, tx_done=0.
//     Release rst, tx_start=1 from reset -> no frame until tx_start drops to 0 and rises again.
//  2. 8N1 frame, tx_data=8'hA5, tx_start 0->1 -> tx=0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
//     tx_busy high for 100 cycles; tx_done one pulse at cycle 100.
//  3. Level flag: hold tx_start=1 for 500 cycles with 8'h3C -> exactly one frame, one tx_done.
//     Drop tx_start 1 cycle, raise again -> second frame.
//  4. Parity: PARITY_EN=1, 8'hA5.
//     Even -> parity bit 0, frame 110 cycles. PARITY_ODD=1 -> parity bit 1.
//     STOP_BITS=2 -> stop high 20 cycles, frame 120 cycles.
//  5. Data stability: accept 8'h0F, change tx_data to 8'hF0 at cycle 30 -> line still carries 0F bits.
//  6. Reset mid-frame: assert rst=0 at cycle 45 of a frame -> tx=1, busy=0 immediately, no tx_done.
//     Release, re-arm and send 8'h55 -> clean frame 0,1,0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises one byte per accepted request as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits. A level request must drop before a new frame is accepted.
module uart_tx_serializer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic             armed_r;
  logic             boundary_s;

  assign boundary_s = (cnt_r == CNT_LAST);

  // Frame sequencer; the bit index doubles as the stop-bit counter since it wraps to 0 after DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      par_r   <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (!tx_start) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            shift_r <= tx_data;
            par_r   <= parity_bit(tx_data, PARITY_ODD);
            armed_r <= 1'b0;
            tx_busy <= 1'b1;
            tx      <= 1'b0;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (boundary_s) begin
            cnt_r   <= '0;
            tx      <= shift_r[0];
            state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (boundary_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              if (PARITY_EN) begin
                tx      <= par_r;
                state_r <= ST_PARITY;
              end else begin
                tx      <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              shift_r <= {1'b0, shift_r[7:1]};
              tx      <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (boundary_s) begin
            cnt_r   <= '0;
            tx      <= 1'b1;
            state_r <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (boundary_s) begin
            cnt_r <= '0;
            if (idx_r == STOP_LAST) begin
              idx_r   <= 3'd0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations (8N1, 8E1, 8O2) share one stimulus stream
// and are compared every cycle against a frame-waveform reference model.
module tb_uart_tx_serializer;

  localparam int BT = 10;
  localparam int PEN [3] = '{0, 1, 1};
  localparam int POD [3] = '{0, 0, 1};
  localparam int SB  [3] = '{1, 1, 2};

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: pos = -1 idle, else cycle index inside the frame
  int  pos     [3];
  bit  armed_m [3];
  bit  done_m  [3];
  int  flen    [3];
  bit  wave    [3][128];

  // observation helpers built from the DUT outputs
  int          busy_cnt [3];
  int          done_cnt [3];
  int          fcyc     [3];
  logic [11:0] cap      [3];

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b0),
                       .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b1),
                       .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b1),
                       .PARITY_ODD(1'b1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i]     = -1;
      armed_m[i] = 1'b0;
      done_m[i]  = 1'b0;
    end
  endtask

  task automatic build_frame(input int i, input logic [7:0] d);
    bit bits [12];
    int n;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int b = 0; b < 8; b++) begin
      bits[n] = d[b]; n++;
    end
    if (PEN[i] != 0) begin
      bits[n] = (^d) ^ (POD[i] != 0); n++;
    end
    for (int s = 0; s < SB[i]; s++) begin
      bits[n] = 1'b1; n++;
    end
    flen[i] = n * BT;
    for (int k = 0; k < n * BT; k++) wave[i][k] = bits[k / BT];
  endtask

  // advance the model across one rising edge, using the inputs present before it
  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        done_m[i] = 1'b0;
        if (pos[i] >= 0) begin
          pos[i]++;
          if (pos[i] == flen[i]) begin
            pos[i]    = -1;
            done_m[i] = 1'b1;
          end
        end else if (!tx_start) begin
          armed_m[i] = 1'b1;
        end else if (armed_m[i]) begin
          build_frame(i, tx_data);
          pos[i]     = 0;
          armed_m[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("i%0d_tx", i), 32'(tx_w[i]), (pos[i] >= 0) ? 32'(wave[i][pos[i]]) : 32'd1);
      check_val($sformatf("i%0d_busy", i), 32'(busy_w[i]), (pos[i] >= 0) ? 32'd1 : 32'd0);
      check_val($sformatf("i%0d_done", i), 32'(done_w[i]), 32'(done_m[i]));
      if (busy_w[i] === 1'b1) busy_cnt[i]++;
      if (done_w[i] === 1'b1) done_cnt[i]++;
      if (busy_w[i] === 1'b1) begin
        if (fcyc[i] == 0) cap[i] = 12'd0;
        if (fcyc[i] % BT == BT / 2) cap[i] = {cap[i][10:0], tx_w[i]};
        fcyc[i]++;
      end else begin
        fcyc[i] = 0;
      end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic new_request(input logic [7:0] d);
    tx_start = 1'b0;
    tick(1);
    tx_data  = d;
    tx_start = 1'b1;
    clear_counts();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      fcyc[i] = 0;
      cap[i]  = 12'd0;
    end
    clear_counts();
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    tick(3);

    // released with the flag already high: must stay idle
    rst = 1'b1;
    clear_counts();
    tick(40);
    check_val("noarm_busy", 32'(busy_cnt[0] + busy_cnt[1] + busy_cnt[2]), 32'd0);
    check_val("noarm_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);

    // A5 on all three formats
    new_request(8'hA5);
    tick(130);
    check_val("a5_busy_8n1", 32'(busy_cnt[0]), 32'd100);
    check_val("a5_busy_8e1", 32'(busy_cnt[1]), 32'd110);
    check_val("a5_busy_8o2", 32'(busy_cnt[2]), 32'd120);
    check_val("a5_done_8n1", 32'(done_cnt[0]), 32'd1);
    check_val("a5_bits_8n1", 32'(cap[0][9:0]), 32'(10'b0101001011));
    check_val("a5_bits_8e1", 32'(cap[1][10:0]), 32'(11'b01010010101));
    check_val("a5_bits_8o2", 32'(cap[2]), 32'(12'b010100101111));

    // flag held high for 500 cycles: one frame only, then re-arm gives a second
    new_request(8'h3C);
    tick(500);
    for (int i = 0; i < 3; i++) check_val($sformatf("hold_done_i%0d", i), 32'(done_cnt[i]), 32'd1);
    new_request(8'h3C);
    tick(130);
    for (int i = 0; i < 3; i++) check_val($sformatf("rearm_done_i%0d", i), 32'(done_cnt[i]), 32'd1);

    // data changed mid-frame must not corrupt the frame in flight
    new_request(8'h0F);
    tick(30);
    tx_data = 8'hF0;
    tick(100);
    check_val("stable_bits_8n1", 32'(cap[0][9:0]), 32'(10'b0111100001));

    // reset mid-frame aborts immediately
    new_request(8'($urandom));
    tick(46);
    rst = 1'b0;
    model_reset();
    #1 check_all();
    check_val("abort_busy", 32'(busy_w), 32'd0);
    check_val("abort_tx", 32'(tx_w), 32'h7);
    tick(3);
    rst = 1'b1;
    clear_counts();
    tick(5);
    check_val("abort_nodone", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
    new_request(8'h55);
    tick(130);
    check_val("after_rst_8n1", 32'(cap[0][9:0]), 32'(10'b0101010101));
    check_val("after_rst_done", 32'(done_cnt[0]), 32'd1);

    // random request flag and data activity, including requests while busy
    for (int it = 0; it < 20; it++) begin
      tx_data = 8'($urandom);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 7) == 0) tx_start = ~tx_start;
        if ($urandom_range(0, 15) == 0) tx_data = 8'($urandom);
        tick(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
